// File: rtl/hog_pkg.sv
// Shared HOG constants and bin-slice index helpers.
package hog_pkg;

    localparam int BINS        = 9;
    localparam int HIST_BINS   = 10;
    localparam int CELL_SIZE   = 8;
    localparam int BLOCK_CELLS = 4;

    // LSB of bin k inside a cell histogram vector.
    function automatic int bin_lsb(input int k, input int bw);
        return k * bw;
    endfunction

    // LSB of bin k of cell c (0=TL,1=TR,2=BL,3=BR) inside a block vector.
    function automatic int block_bin_lsb(input int c, input int k, input int bw);
        return (c * BINS + k) * bw;
    endfunction

endpackage

// File: rtl/block_assembler_if.sv
// Cell-in / block-out stream bundle. The slave modport is the assembler side.
interface block_assembler_if #(
    parameter int BW = 14,
    parameter int SW = 16
);
    logic                                        in_valid;
    logic                                        in_ready;
    logic [hog_pkg::HIST_BINS*BW-1:0]            cell_histogram;
    logic                                        out_valid;
    logic                                        out_ready;
    logic [hog_pkg::BLOCK_CELLS*hog_pkg::BINS*BW-1:0] block_histogram;
    logic [SW-1:0]                               block_sum;

    modport master (
        output in_valid, cell_histogram, out_ready,
        input  in_ready, out_valid, block_histogram, block_sum
    );

    modport slave (
        input  in_valid, cell_histogram, out_ready,
        output in_ready, out_valid, block_histogram, block_sum
    );
endinterface

// File: rtl/hog_line_ram.sv
// One-row cell buffer: single write port, asynchronous read (read-before-write).
module hog_line_ram #(
    parameter int DEPTH = 80,
    parameter int WIDTH = 140,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming cell; a same-address read this cycle still sees the old row.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/block_assembler.sv
// Builds overlapping 2x2-cell HOG blocks (stride 1 cell) from a raster cell stream.
module block_assembler
    import hog_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int BIN_WIDTH    = 14,
    parameter int SUM_WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    block_assembler_if.slave bus
);
    localparam int BW  = BIN_WIDTH;
    localparam int CPR = IMAGE_WIDTH / CELL_SIZE;
    localparam int CPC = IMAGE_HEIGHT / CELL_SIZE;
    localparam int CW  = (CPR > 1) ? $clog2(CPR) : 1;
    localparam int RW  = (CPC > 1) ? $clog2(CPC) : 1;
    localparam int HW  = HIST_BINS * BW;
    localparam int BHW = BLOCK_CELLS * BINS * BW;
    localparam logic [CW-1:0] COL_LAST = CW'(CPR - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(CPC - 1);

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [HW-1:0]          top_prev_q, top_prev_d;
    logic [HW-1:0]          cur_prev_q, cur_prev_d;
    logic                   out_valid_q, out_valid_d;
    logic [BHW-1:0]         blk_q, blk_d;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [HW-1:0]          top_rd;
    logic [BLOCK_CELLS-1:0][HW-1:0] cells;
    logic                   accept, emit;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign emit         = accept && (row_q != '0) && (col_q != '0);

    hog_line_ram #(.DEPTH(CPR), .WIDTH(HW), .AW(CW)) u_line_ram (
        .clk     (clk),
        .we_i    (accept && !rst),
        .waddr_i (col_q),
        .wdata_i (bus.cell_histogram),
        .raddr_i (col_q),
        .rdata_o (top_rd)
    );

    // Raster position and previous-column cells advance on every accepted cell.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        top_prev_d = top_prev_q;
        cur_prev_d = cur_prev_q;
        if (accept) begin
            top_prev_d = top_rd;
            cur_prev_d = bus.cell_histogram;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Block assembly: drop each cell's sum bin from the bin vector, add the four sums.
    always_comb begin
        cells[0]    = top_prev_q;
        cells[1]    = top_rd;
        cells[2]    = cur_prev_q;
        cells[3]    = bus.cell_histogram;
        blk_d       = blk_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        if (emit) begin
            out_valid_d = 1'b1;
            sum_d       = '0;
            for (int c = 0; c < BLOCK_CELLS; c++) begin
                for (int k = 0; k < BINS; k++)
                    blk_d[block_bin_lsb(c, k, BW) +: BW] = cells[c][bin_lsb(k, BW) +: BW];
                sum_d = sum_d + SUM_WIDTH'(cells[c][bin_lsb(BINS, BW) +: BW]);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; the line RAM is deliberately left uncleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            top_prev_q  <= '0;
            cur_prev_q  <= '0;
            out_valid_q <= 1'b0;
            blk_q       <= '0;
            sum_q       <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            top_prev_q  <= top_prev_d;
            cur_prev_q  <= cur_prev_d;
            out_valid_q <= out_valid_d;
            blk_q       <= blk_d;
            sum_q       <= sum_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.block_histogram = blk_q;
    assign bus.block_sum       = sum_q;
endmodule

// File: tb/tb_block_assembler.sv
// Directed bench: 3x3-cell frames against a grid-based block model.
module tb_block_assembler;
    localparam int BW = 14;
    localparam int SW = 16;

    typedef struct {
        logic [503:0] h;
        logic [15:0]  s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_assembler_if #(.BW(BW), .SW(SW)) bus ();

    block_assembler #(.IMAGE_WIDTH(24), .IMAGE_HEIGHT(24), .BIN_WIDTH(BW), .SUM_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0, n_fail = 0, blk_cnt = 0;
    int mr = 0, mc = 0;
    logic [15:0] first_sum = '0, last_sum = '0;
    logic [139:0] grid [3][3];
    exp_t exp_q [$];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [139:0] mk(input int v, input int s);
        logic [139:0] c;
        logic [31:0] vv, ss;
        vv = v; ss = s;
        for (int k = 0; k < 9; k++) c[k*14 +: 14] = vv[13:0];
        c[126 +: 14] = ss[13:0];
        return c;
    endfunction

    function automatic exp_t compose(input logic [139:0] a, b, c, d);
        logic [3:0][139:0] cl;
        exp_t e;
        cl[0] = a; cl[1] = b; cl[2] = c; cl[3] = d;
        e.h = '0;
        for (int ci = 0; ci < 4; ci++)
            for (int k = 0; k < 9; k++)
                e.h[(ci*9+k)*14 +: 14] = cl[ci][k*14 +: 14];
        e.s = 16'(a[139:126]) + 16'(b[139:126]) + 16'(c[139:126]) + 16'(d[139:126]);
        return e;
    endfunction

    task automatic model_accept(input logic [139:0] v);
        grid[mr][mc] = v;
        if (mr >= 1 && mc >= 1)
            exp_q.push_back(compose(grid[mr-1][mc-1], grid[mr-1][mc], grid[mr][mc-1], grid[mr][mc]));
        if (mc == 2) begin
            mc = 0;
            mr = (mr == 2) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    // Present a cell and hold it until the handshake completes.
    task automatic push(input logic [139:0] v);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.cell_histogram = v;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (t >= 200) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        model_accept(v);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) return;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic send_frame(input int base);
        for (int n = 0; n < 9; n++) push(mk(base + n, 9 * (base + n)));
    endtask

    // Scoreboard: every consumed block must be the next one the grid model predicts.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            exp_t e;
            blk_cnt++;
            if (blk_cnt == 1) first_sum = bus.block_sum;
            last_sum = bus.block_sum;
            if (exp_q.size() == 0) begin
                chk("unexpected_block", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("blk_hist", bus.block_histogram, e.h);
                chk("blk_sum", bus.block_sum, e.s);
            end
        end
    end

    initial begin
        int c0;
        logic [503:0] held_h;
        logic [15:0]  held_s;
        bus.in_valid = 1'b1;
        bus.cell_histogram = '0;
        bus.out_ready = 1'b1;

        // Reset with a pending valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_hist", bus.block_histogram, 0);
        chk("rst_sum", bus.block_sum, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;

        // Frame 1: row 0 alone must not emit.
        for (int n = 0; n < 3; n++) push(mk(n, 9 * n));
        idle();
        repeat (2) @(negedge clk);
        chk("row0_no_block", blk_cnt, 0);
        for (int n = 3; n < 9; n++) push(mk(n, 9 * n));
        idle();
        drain();
        chk("frame1_blocks", blk_cnt, 4);
        chk("first_sum", first_sum, 72);

        // Same frame with a 5-cycle downstream stall on the first block.
        c0 = blk_cnt;
        fork
            send_frame(0);
            begin
                for (int t = 0; t < 100; t++) begin
                    @(posedge clk); #1;
                    if (bus.out_valid) break;
                end
                chk("stall_saw_valid", bus.out_valid, 1);
                bus.out_ready = 1'b0;
                held_h = bus.block_histogram;
                held_s = bus.block_sum;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", bus.in_ready, 0);
                    chk("stall_out_valid", bus.out_valid, 1);
                    chk("stall_hist_held", bus.block_histogram, held_h);
                    chk("stall_sum_held", bus.block_sum, held_s);
                end
                chk("stall_sum_val", held_s, 72);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        idle();
        drain();
        chk("stall_blocks", blk_cnt - c0, 4);

        // Two frames back to back.
        c0 = blk_cnt;
        send_frame(10);
        send_frame(20);
        idle();
        drain();
        chk("two_frame_blocks", blk_cnt - c0, 8);

        // Saturated bins and sums.
        c0 = blk_cnt;
        for (int n = 0; n < 9; n++) push(mk(16383, 16383));
        idle();
        drain();
        chk("sat_blocks", blk_cnt - c0, 4);
        chk("sat_sum", last_sum, 65532);

        // Reset after cell 4 of a frame, then a fresh frame.
        for (int n = 0; n < 5; n++) push(mk(40 + n, 9 * (40 + n)));
        idle();
        drain();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mr = 0; mc = 0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        c0 = blk_cnt;
        send_frame(30);
        idle();
        drain();
        chk("midrst_blocks", blk_cnt - c0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
